wb_sram_slave: RTL and testbench
================================

// Module: wb_sram_slave
// PURPOSE
//  Wishbone B4 slave terminating one slave port (s0 or s1) of the 1x2 interconnect and driving a synchronous
//  single-port SRAM macro with 1-cycle read latency.
//  Supports classic cycles and registered-feedback bursts:
//  - constant-address bursts (CTI=001)
//  - incrementing bursts (CTI=010) with linear/wrap-4/8/16 (BTE)
//  Zero-wait-state beats inside a burst. Out-of-window accesses are terminated with ERR.
// PARAMETERS
//  WB_ADDR_WIDTH   32    Wishbone byte-address width
//  WB_DATA_WIDTH   32    Wishbone data width; power of 2, >=8
//  MEM_ADDR_WIDTH  10    SRAM word-index width; depth = 2**MEM_ADDR_WIDTH words
//  ADDR_BASE       'h0   byte address of SRAM word 0; must equal the matching SLAVEn_ADDR_BASE
// PORTS
//  clk         in   1               system clock
//  rstn        in   1               asynchronous active-low reset
//  s           -    wb_if.slave     Wishbone slave: ADR CTI BTE DAT_W SEL CYC STB WE in; DAT_R ACK ERR out
//  sram_cs     out  1               SRAM chip select, this cycle
//  sram_we     out  1               SRAM write enable (qualified by sram_cs)
//  sram_be     out  WB_DATA_WIDTH/8 SRAM byte enables = SEL
//  sram_addr   out  MEM_ADDR_WIDTH  SRAM word index
//  sram_wdata  out  WB_DATA_WIDTH   SRAM write data = DAT_W
//  sram_rdata  in   WB_DATA_WIDTH   SRAM read data, valid the cycle after a read select
// BEHAVIOUR
//  Reset (async, rstn=0): ACK=0, ERR=0, DAT_R=0, rd_q=0; sram_cs/sram_we forced 0 while rstn=0.
//  Decode (combinational on current ADR):
//  - off = ADR-ADDR_BASE; idx = off>>log2(DW/8)
//  - in_range = ADR>=ADDR_BASE && off < 2**MEM_ADDR_WIDTH*(DW/8)
//  req = CYC&STB. Handshake cycle = req&ACK. Regs: ack_q (drives ACK), err_q (drives ERR), rd_q (=ACK of a read).
//  ack_q next = req & in_range & !ERR & (!ACK | cont)
//  - cont = ACK & CTI in {001,010} & next_idx in range
//  - CTI=000 or 111 on a handshake ends the run: ACK drops next cycle
//  - Classic: request cycle, then ACK cycle; 2 cycles per access.
//  err_q next = req & !in_range & !ACK & !ERR
//  - ERR pulses one cycle; no SRAM access; ACK stays 0.
//  - Burst whose predicted next_idx leaves the window: ACK drops after the current beat; the master's next
//    out-of-range request then gets ERR.
//  next_idx (from current idx, BTE): CTI=001 -> idx; CTI=010 -> idx+1 within the wrap window.
//  - BTE 00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
//  - Wrap replaces low 2/3/4 bits with (bits+1) mod window.
//  Writes (WE=1): committed on the handshake cycle.
//  - sram_cs=sram_we=1, sram_addr=idx, be=SEL, wdata=DAT_W
//  - Each beat writes exactly once; request cycles before the first ACK do not write.
//  Reads (WE=0): sram_cs=1 while req & in_range & !ERR & ack_q-next-would-be-1.
//  - sram_addr = ACK ? next_idx : idx (prefetch), so data lands on the ACK cycle.
//  - DAT_R = rd_q ? sram_rdata : 0.
//  CYC or STB dropped mid-burst: ACK/ERR 0 next cycle, prefetched read data discarded, no SRAM write.
//  WE, SEL, BTE and the CTI class are constant within a burst (master obligation, not checked).
//  Back-to-back classic cycles: one request cycle per access; ACK never asserted two cycles in a row for CTI=000.
// STRUCTURE
//  wb_pkg (shared):
//  - CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111
//  - BTE_LINEAR/WRAP4/WRAP8/WRAP16 = 2'b00..2'b11
//  Sub-module wb_burst_addr_next (combinational: idx, CTI, BTE -> next_idx). Reused by future burst slaves.
//  Top holds decode, ack/err/rd registers and SRAM muxing.
// TESTING (ADDR_BASE='h1000, MEM_ADDR_WIDTH=10, DW=32; bench SRAM model has 1-cycle read)
//  1 Classic write 0xDEADBEEF @0x1010 SEL=F -> ACK in cycle 2 with sram write idx 4 that cycle;
//    classic read @0x1010 -> ACK cycle 2, DAT_R=0xDEADBEEF, ACK low cycle 3.
//  2 Incr read, 4 beats, BTE=00 from 0x1008, last beat CTI=111 -> ACK 4 consecutive cycles;
//    sram_addr 2,3,4,5; no 5th select; ACK low after.
//  3 Incr read, wrap-4 from idx 6 (0x1018) -> beats return indices 6,7,4,5 in 4 consecutive ACK cycles.
//  4 Preload idx 8 = 0x11223344; write SEL=0010 DAT_W=0x0000AB00 @0x1020; read back -> 0x1122AB44.
//  5 Read @0x2000 (first out of range) -> ERR 1 cycle after STB, ACK 0, sram_cs never 1;
//    incr burst ending at idx 1023 -> ACK drops after idx 1023.
//  6 rstn low during beat 2 of an 8-beat write burst -> ACK/ERR/sram_cs 0 immediately, beats 3..8 not written;
//    after release, classic read of idx of beat 1 returns its data.

Source files
------------

// File: rtl/wb_pkg.sv
// Purpose: shared Wishbone B4 encodings (cycle type and burst type) used by the
//          burst-capable slaves and their interface.
// Ports:   none (package).
package wb_pkg;

   // Cycle type identifier (CTI) values.
   typedef enum logic [2:0] {
      CTI_CLASSIC = 3'b000,
      CTI_CONST   = 3'b001,
      CTI_INCR    = 3'b010,
      CTI_EOB     = 3'b111
   } cti_e;

   // Burst type extension (BTE) values.
   typedef enum logic [1:0] {
      BTE_LINEAR = 2'b00,
      BTE_WRAP4  = 2'b01,
      BTE_WRAP8  = 2'b10,
      BTE_WRAP16 = 2'b11
   } bte_e;

endpackage

// File: rtl/wb_if.sv
// Purpose: Wishbone B4 bus bundle with registered-feedback burst tags.
// Ports:   master modport drives adr/cti/bte/dat_w/sel/cyc/stb/we and receives
//          dat_r/ack/err; slave modport is the mirror image.
interface wb_if #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
);
   logic [AW-1:0]   adr;
   logic [2:0]      cti;
   logic [1:0]      bte;
   logic [DW-1:0]   dat_w;
   logic [DW-1:0]   dat_r;
   logic [DW/8-1:0] sel;
   logic            cyc;
   logic            stb;
   logic            we;
   logic            ack;
   logic            err;

   modport master (
      output adr, cti, bte, dat_w, sel, cyc, stb, we,
      input  dat_r, ack, err
   );

   modport slave (
      input  adr, cti, bte, dat_w, sel, cyc, stb, we,
      output dat_r, ack, err
   );
endinterface

// File: rtl/wb_burst_addr_next.sv
// Purpose: predicts the word index of the next burst beat from the current
//          index, cycle type and burst type (purely combinational).
// Ports:   idx_i        current word index
//          cti_i        cycle type of the current beat
//          bte_i        burst type extension
//          next_idx_c_o predicted index of the following beat
module wb_burst_addr_next
   import wb_pkg::*;
#(
   parameter int unsigned IDX_WIDTH = 10
) (
   input  logic [IDX_WIDTH-1:0] idx_i,
   input  logic [2:0]           cti_i,
   input  logic [1:0]           bte_i,
   output logic [IDX_WIDTH-1:0] next_idx_c_o
);

   logic [IDX_WIDTH-1:0] inc_c;

   assign inc_c = idx_i + IDX_WIDTH'(1);

   // Wrap bursts keep the upper bits and take the low bits of idx+1 (mod window).
   always_comb begin
      next_idx_c_o = idx_i;
      if (cti_i == CTI_INCR) begin
         case (bte_i)
            BTE_LINEAR: next_idx_c_o = inc_c;
            BTE_WRAP4:  next_idx_c_o = {idx_i[IDX_WIDTH-1:2], inc_c[1:0]};
            BTE_WRAP8:  next_idx_c_o = {idx_i[IDX_WIDTH-1:3], inc_c[2:0]};
            default:    next_idx_c_o = {idx_i[IDX_WIDTH-1:4], inc_c[3:0]};
         endcase
      end
   end

endmodule

// File: rtl/wb_sram_slave.sv
// Purpose: Wishbone B4 slave mapping a window of the bus onto a synchronous
//          single-port SRAM (1-cycle read latency). Classic cycles take two
//          cycles; constant/incrementing bursts run at one beat per cycle.
//          Accesses outside the window are answered with a single ERR pulse.
// Ports:   clk, rstn    clock, asynchronous active-low reset
//          s            Wishbone slave port
//          sram_cs/we   SRAM select and write enable (combinational)
//          sram_be      byte enables (= SEL)
//          sram_addr    SRAM word index
//          sram_wdata   write data (= DAT_W)
//          sram_rdata   read data, valid the cycle after a read select
module wb_sram_slave
   import wb_pkg::*;
#(
   parameter int unsigned              WB_ADDR_WIDTH  = 32,
   parameter int unsigned              WB_DATA_WIDTH  = 32,
   parameter int unsigned              MEM_ADDR_WIDTH = 10,
   parameter logic [WB_ADDR_WIDTH-1:0] ADDR_BASE      = '0
) (
   input  logic                        clk,
   input  logic                        rstn,
   wb_if.slave                         s,
   output logic                        sram_cs,
   output logic                        sram_we,
   output logic [WB_DATA_WIDTH/8-1:0]  sram_be,
   output logic [MEM_ADDR_WIDTH-1:0]   sram_addr,
   output logic [WB_DATA_WIDTH-1:0]    sram_wdata,
   input  logic [WB_DATA_WIDTH-1:0]    sram_rdata
);

   localparam int unsigned BE_W = WB_DATA_WIDTH / 8;
   localparam int unsigned LSB  = $clog2(BE_W);
   localparam logic [WB_ADDR_WIDTH:0] WIN_BYTES =
      (WB_ADDR_WIDTH + 1)'(1) << (MEM_ADDR_WIDTH + LSB);

   logic [WB_ADDR_WIDTH-1:0]  off_c;
   logic [MEM_ADDR_WIDTH-1:0] idx_c;
   logic [MEM_ADDR_WIDTH-1:0] next_idx_c;
   logic                      in_range_c;
   logic                      req_c;
   logic                      next_ok_c;
   logic                      cont_c;
   logic                      ack_q, ack_d;
   logic                      err_q, err_d;
   logic                      rd_q,  rd_d;

   // Address decode against the SRAM window.
   assign off_c      = s.adr - ADDR_BASE;
   assign idx_c      = off_c[MEM_ADDR_WIDTH+LSB-1:LSB];
   assign in_range_c = (s.adr >= ADDR_BASE) && ({1'b0, off_c} < WIN_BYTES);
   assign req_c      = s.cyc & s.stb;

   wb_burst_addr_next #(
      .IDX_WIDTH (MEM_ADDR_WIDTH)
   ) u_next (
      .idx_i        (idx_c),
      .cti_i        (s.cti),
      .bte_i        (s.bte),
      .next_idx_c_o (next_idx_c)
   );

   // Only a linear increment from the top word can leave the window.
   assign next_ok_c = !((s.cti == CTI_INCR) && (s.bte == BTE_LINEAR) && (&idx_c));
   assign cont_c    = ack_q && ((s.cti == CTI_CONST) || (s.cti == CTI_INCR)) && next_ok_c;

   // Next-state of the handshake registers.
   always_comb begin
      ack_d = req_c & in_range_c & ~err_q & (~ack_q | cont_c);
      err_d = req_c & ~in_range_c & ~ack_q & ~err_q;
      rd_d  = ack_d & ~s.we;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         rd_q  <= 1'b0;
      end else begin
         ack_q <= ack_d;
         err_q <= err_d;
         rd_q  <= rd_d;
      end
   end

   assign s.ack   = ack_q;
   assign s.err   = err_q;
   assign s.dat_r = rd_q ? sram_rdata : '0;

   // Writes commit on the handshake; reads select one cycle ahead so data
   // lands on the ACK cycle (prefetching next_idx while a burst continues).
   assign sram_we    = rstn & req_c & ack_q & s.we;
   assign sram_cs    = rstn & ((req_c & ack_q & s.we) | (ack_d & ~s.we));
   assign sram_addr  = (!s.we && ack_q) ? next_idx_c : idx_c;
   assign sram_be    = s.sel;
   assign sram_wdata = s.dat_w;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Purpose: directed self-checking bench for wb_sram_slave with a 1-cycle-read
//          SRAM model; window at 0x1000, 1024 x 32-bit words.
module tb_wb_sram_slave;
   import wb_pkg::*;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   wb_if #(.AW(32), .DW(32)) bus ();

   logic        sram_cs, sram_we;
   logic [3:0]  sram_be;
   logic [9:0]  sram_addr;
   logic [31:0] sram_wdata, sram_rdata;

   wb_sram_slave #(
      .WB_ADDR_WIDTH  (32),
      .WB_DATA_WIDTH  (32),
      .MEM_ADDR_WIDTH (10),
      .ADDR_BASE      (32'h1000)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .s          (bus),
      .sram_cs    (sram_cs),
      .sram_we    (sram_we),
      .sram_be    (sram_be),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   // SRAM model: unwritten words read as 0x5A00_0000 | index.
   logic [31:0] mem [1024];
   bit          written [1024];
   logic [31:0] mdl_w;

   function automatic logic [31:0] init_word(input int i);
      return 32'h5A00_0000 | 32'(i);
   endfunction

   always @(posedge clk) begin
      if (sram_cs) begin
         mdl_w = written[sram_addr] ? mem[sram_addr] : init_word(int'(sram_addr));
         if (sram_we) begin
            for (int b = 0; b < 4; b++)
               if (sram_be[b]) mdl_w[8*b +: 8] = sram_wdata[8*b +: 8];
            mem[sram_addr]     <= mdl_w;
            written[sram_addr] <= 1'b1;
         end else begin
            sram_rdata <= mdl_w;
         end
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] b_adr [4];
   logic [9:0]  b_idx [4];
   logic [31:0] b_dat [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic idle();
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0; bus.cti = 3'b000;
      bus.bte = 2'b00; bus.sel = 4'h0; bus.adr = '0; bus.dat_w = '0;
   endtask

   task automatic drive(input logic [31:0] a, input logic w, input logic [2:0] c,
                        input logic [1:0] b, input logic [3:0] sl, input logic [31:0] d);
      bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w; bus.cti = c;
      bus.bte = b; bus.sel = sl; bus.adr = a; bus.dat_w = d;
   endtask

   task automatic classic_write(input string tag, input logic [31:0] a, input logic [9:0] idx,
                                input logic [3:0] sl, input logic [31:0] d);
      drive(a, 1'b1, CTI_CLASSIC, BTE_LINEAR, sl, d);
      sample();
      chk({tag, "_req_ack"}, 32'(bus.ack), 32'd0);
      chk({tag, "_req_cs"}, 32'(sram_cs), 32'd0);
      tick();
      sample();
      chk({tag, "_ack"}, 32'(bus.ack), 32'd1);
      chk({tag, "_we"}, 32'(sram_cs & sram_we), 32'd1);
      chk({tag, "_addr"}, 32'(sram_addr), 32'(idx));
      tick();
      idle();
   endtask

   task automatic classic_read(input string tag, input logic [31:0] a, input logic [9:0] idx,
                               input logic [31:0] exp);
      drive(a, 1'b0, CTI_CLASSIC, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk({tag, "_req_ack"}, 32'(bus.ack), 32'd0);
      chk({tag, "_req_addr"}, 32'(sram_addr), 32'(idx));
      tick();
      sample();
      chk({tag, "_ack"}, 32'(bus.ack), 32'd1);
      chk({tag, "_data"}, bus.dat_r, exp);
      tick();
      idle();
   endtask

   task automatic burst_read4(input string tag, input logic [1:0] bte);
      drive(b_adr[0], 1'b0, CTI_INCR, bte, 4'hF, 32'h0);
      sample();
      chk({tag, "_req_ack"}, 32'(bus.ack), 32'd0);
      chk({tag, "_req_addr"}, 32'(sram_addr), 32'(b_idx[0]));
      tick();
      for (int k = 0; k < 4; k++) begin
         sample();
         chk($sformatf("%s_b%0d_ack", tag, k), 32'(bus.ack), 32'd1);
         chk($sformatf("%s_b%0d_data", tag, k), bus.dat_r, b_dat[k]);
         if (k < 3) begin
            chk($sformatf("%s_b%0d_pf", tag, k), 32'(sram_cs), 32'd1);
            chk($sformatf("%s_b%0d_pfaddr", tag, k), 32'(sram_addr), 32'(b_idx[k+1]));
         end else begin
            chk($sformatf("%s_b%0d_nocs", tag, k), 32'(sram_cs), 32'd0);
         end
         tick();
         if (k < 2)       drive(b_adr[k+1], 1'b0, CTI_INCR, bte, 4'hF, 32'h0);
         else if (k == 2) drive(b_adr[3], 1'b0, CTI_EOB, bte, 4'hF, 32'h0);
         else             idle();
      end
      sample();
      chk({tag, "_end_ack"}, 32'(bus.ack), 32'd0);
      tick();
   endtask

   initial begin
      // Reset with a pending request: selects must stay forced low.
      rstn = 1'b0;
      drive(32'h1000, 1'b0, CTI_CLASSIC, BTE_LINEAR, 4'hF, 32'h0);
      #2;
      chk("rst_ack", 32'(bus.ack), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_dat", bus.dat_r, 32'd0);
      chk("rst_cs", 32'(sram_cs), 32'd0);
      tick();
      tick();
      idle();
      rstn = 1'b1;
      tick();

      // 1: classic write then classic read, held for a back-to-back access.
      classic_write("t1_wr", 32'h1010, 10'd4, 4'hF, 32'hDEADBEEF);
      drive(32'h1010, 1'b0, CTI_CLASSIC, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk("t1_rd_c1_ack", 32'(bus.ack), 32'd0);
      chk("t1_rd_c1_addr", 32'(sram_addr), 32'd4);
      tick();
      sample();
      chk("t1_rd_c2_ack", 32'(bus.ack), 32'd1);
      chk("t1_rd_c2_data", bus.dat_r, 32'hDEADBEEF);
      tick();
      sample();
      chk("t1_rd_c3_ack", 32'(bus.ack), 32'd0);
      tick();
      sample();
      chk("t1_rd_c4_ack", 32'(bus.ack), 32'd1);
      chk("t1_rd_c4_data", bus.dat_r, 32'hDEADBEEF);
      tick();
      idle();
      tick();

      // 2: linear incrementing read, 4 beats from 0x1008.
      b_adr[0] = 32'h1008; b_adr[1] = 32'h100C; b_adr[2] = 32'h1010; b_adr[3] = 32'h1014;
      b_idx[0] = 10'd2;    b_idx[1] = 10'd3;    b_idx[2] = 10'd4;    b_idx[3] = 10'd5;
      b_dat[0] = 32'h5A000002; b_dat[1] = 32'h5A000003;
      b_dat[2] = 32'hDEADBEEF; b_dat[3] = 32'h5A000005;
      burst_read4("t2", BTE_LINEAR);

      // 3: wrap-4 read from index 6: 6,7,4,5.
      b_adr[0] = 32'h1018; b_adr[1] = 32'h101C; b_adr[2] = 32'h1010; b_adr[3] = 32'h1014;
      b_idx[0] = 10'd6;    b_idx[1] = 10'd7;    b_idx[2] = 10'd4;    b_idx[3] = 10'd5;
      b_dat[0] = 32'h5A000006; b_dat[1] = 32'h5A000007;
      b_dat[2] = 32'hDEADBEEF; b_dat[3] = 32'h5A000005;
      burst_read4("t3", BTE_WRAP4);

      // 4: byte-lane write merge.
      classic_write("t4_pre", 32'h1020, 10'd8, 4'hF, 32'h11223344);
      classic_write("t4_wr", 32'h1020, 10'd8, 4'b0010, 32'h0000AB00);
      classic_read("t4_rd", 32'h1020, 10'd8, 32'h1122AB44);

      // 5a: out-of-window read above the window.
      drive(32'h2000, 1'b0, CTI_CLASSIC, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk("t5_hi_c1_err", 32'(bus.err), 32'd0);
      chk("t5_hi_c1_cs", 32'(sram_cs), 32'd0);
      tick();
      sample();
      chk("t5_hi_c2_err", 32'(bus.err), 32'd1);
      chk("t5_hi_c2_ack", 32'(bus.ack), 32'd0);
      chk("t5_hi_c2_cs", 32'(sram_cs), 32'd0);
      tick();
      idle();
      sample();
      chk("t5_hi_c3_err", 32'(bus.err), 32'd0);
      tick();

      // 5b: below the base.
      drive(32'h0FFC, 1'b0, CTI_CLASSIC, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk("t5_lo_c1_cs", 32'(sram_cs), 32'd0);
      tick();
      sample();
      chk("t5_lo_c2_err", 32'(bus.err), 32'd1);
      chk("t5_lo_c2_ack", 32'(bus.ack), 32'd0);
      tick();
      idle();
      tick();

      // 5c: linear burst running off the top of the window.
      drive(32'h1FF8, 1'b0, CTI_INCR, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk("t5_top_c1_addr", 32'(sram_addr), 32'd1022);
      tick();
      sample();
      chk("t5_top_c2_ack", 32'(bus.ack), 32'd1);
      chk("t5_top_c2_data", bus.dat_r, 32'h5A0003FE);
      chk("t5_top_c2_pf", 32'(sram_addr), 32'd1023);
      tick();
      drive(32'h1FFC, 1'b0, CTI_INCR, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk("t5_top_c3_ack", 32'(bus.ack), 32'd1);
      chk("t5_top_c3_data", bus.dat_r, 32'h5A0003FF);
      chk("t5_top_c3_nocs", 32'(sram_cs), 32'd0);
      tick();
      drive(32'h2000, 1'b0, CTI_INCR, BTE_LINEAR, 4'hF, 32'h0);
      sample();
      chk("t5_top_c4_ack", 32'(bus.ack), 32'd0);
      chk("t5_top_c4_err", 32'(bus.err), 32'd0);
      tick();
      sample();
      chk("t5_top_c5_err", 32'(bus.err), 32'd1);
      chk("t5_top_c5_ack", 32'(bus.ack), 32'd0);
      tick();
      idle();
      tick();

      // 6: reset during beat 2 of an 8-beat write burst.
      drive(32'h1040, 1'b1, CTI_INCR, BTE_LINEAR, 4'hF, 32'hC0DE0000);
      sample();
      chk("t6_c1_ack", 32'(bus.ack), 32'd0);
      tick();
      sample();
      chk("t6_b1_ack", 32'(bus.ack), 32'd1);
      chk("t6_b1_we", 32'(sram_cs & sram_we), 32'd1);
      chk("t6_b1_addr", 32'(sram_addr), 32'd16);
      tick();
      drive(32'h1044, 1'b1, CTI_INCR, BTE_LINEAR, 4'hF, 32'hC0DE0001);
      chk("t6_b2_ack_pre", 32'(bus.ack), 32'd1);
      rstn = 1'b0;
      #1;
      chk("t6_rst_ack", 32'(bus.ack), 32'd0);
      chk("t6_rst_err", 32'(bus.err), 32'd0);
      chk("t6_rst_cs", 32'(sram_cs), 32'd0);
      for (int k = 2; k < 8; k++) begin
         tick();
         drive(32'h1040 + 32'(4 * k), 1'b1, (k == 7) ? CTI_EOB : CTI_INCR, BTE_LINEAR,
               4'hF, 32'hC0DE0000 + 32'(k));
         sample();
         chk($sformatf("t6_rst_b%0d_cs", k + 1), 32'(sram_cs), 32'd0);
      end
      tick();
      idle();
      rstn = 1'b1;
      tick();
      for (int i = 17; i < 24; i++)
         chk($sformatf("t6_nowr_%0d", i), 32'(written[i]), 32'd0);
      classic_read("t6_rd", 32'h1040, 10'd16, 32'hC0DE0000);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
